ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter MAX_DBURST, default 4, meaning max consecutive data grants while any instruction request waits.
REQ-002 CLK  input  1  system clock, all state on rising edge.
REQ-003 nRST  input  1  reset, synchronous, active-low.
REQ-004 iREN  input  2  instruction read request, one bit per CPU.
REQ-005 iaddr  input  2x32  instruction address per CPU.
REQ-006 iwait  output  2  instruction wait per CPU; low for exactly the completing cycle.
REQ-007 iload  output  2x32  instruction word per CPU; valid when matching iwait low.
REQ-008 dREN, dWEN  input  1 each  data read/write request from coherence bus controller.
REQ-009 daddr, dstore  input  32 each  data address and write word.
REQ-010 dwait  output  1  data wait; low for exactly the completing cycle.
REQ-011 dload  output  32  data read word; valid when dwait low.
REQ-012 ramREN, ramWEN  output  1 each  RAM enables.
REQ-013 ramaddr, ramstore  output  32 each  RAM address and write word.
REQ-014 ramload  input  32  RAM read word.
REQ-015 ramstate  input  ramstate_t  RAM status (FREE, BUSY, ACCESS, ERROR).

Function
REQ-016 FSM states IDLE, GNT_D, GNT_I0, GNT_I1; exactly one owner of RAM outside IDLE.
REQ-017 Arbitration evaluated in IDLE and on the completion cycle of any grant; chosen owner takes state next cycle (one-cycle request-to-drive latency).
REQ-018 Priority: data (dREN|dWEN) over instruction, unless burst counter equals MAX_DBURST and an iREN is pending, then instruction wins.
REQ-019 Instruction ties broken round-robin by rr_ptr; rr_ptr toggles to other CPU on each instruction completion; reset value CPU0.
REQ-020 Burst counter, 3 bits minimum, increments on each data completion while any iREN high, clears on any instruction completion or when no iREN pending, saturates at MAX_DBURST.
REQ-021 In GNT_D: ramaddr=daddr; dWEN gives ramWEN=1, ramREN=0, ramstore=dstore; else ramREN=1; dload=ramload.
REQ-022 In GNT_Ix: ramaddr=iaddr[x], ramREN=1, ramWEN=0, iload[x]=ramload.
REQ-023 Completion = owner state and ramstate==ACCESS; owner's wait low that cycle only; all non-owner waits high always.
REQ-024 ramstate ERROR or BUSY: grant held, wait high, enables held.
REQ-025 Owner request dropped before completion: enables low in that same cycle (combinational), next state IDLE, counters unchanged.
REQ-026 dREN and dWEN both high: treated as write.
REQ-027 In IDLE all RAM enables low, ramaddr/ramstore zero, all waits high, loads zero.
REQ-028 No new grant while current grant incomplete, regardless of higher-priority arrivals.

Reset
REQ-029 nRST low at a rising edge: state IDLE, rr_ptr CPU0, burst counter 0, applied even mid-grant, in-flight transaction abandoned without completion pulse.
REQ-030 Reset outputs: iwait=2'b11, dwait=1, ramREN=ramWEN=0, ramaddr, ramstore, iload, dload all zero.

Structure
REQ-031 arb_state_t enum and MAX_DBURST default belong in cpu_types_pkg; word_t and ramstate_t reused from it.
REQ-032 One sub-module rr_picker (2-way round-robin select from request vector and pointer), combinational.

Verification
REQ-033 iREN=2'b11, ramstate ACCESS every 2nd cycle -> completions alternate CPU0, CPU1, CPU0, CPU1.
REQ-034 dWEN=1 daddr=0x40 dstore=0xDEADBEEF with iREN[0]=1 -> GNT_D first, ramWEN=1 ramaddr=0x40, dwait low on ACCESS, then GNT_I0.
REQ-035 dREN held continuously, iREN[1]=1, MAX_DBURST=4 -> exactly 4 data completions, then one CPU1 instruction completion, then data resumes.
REQ-036 GNT_I0 with ramstate BUSY, drop iREN[0] -> ramREN low same cycle, IDLE next cycle, iwait[0] never low.
REQ-037 nRST low during GNT_D with ramstate ACCESS pending -> next cycle IDLE, dwait=1, all REQ-030 values, rr_ptr=CPU0.
REQ-038 ramstate ERROR for 5 cycles during GNT_I1 -> grant and ramaddr=iaddr[1] held, iwait[1] high, completes on first ACCESS.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types: word and RAM status types, arbiter state encoding
// and the default data-burst limit used by ram_arbiter.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_D  = 2'd1,
    GNT_I0 = 2'd2,
    GNT_I1 = 2'd3
  } arb_state_t;

  localparam int DEFAULT_MAX_DBURST = 4;

  // Burst counter is at least 3 bits and wide enough to hold max_burst itself.
  function automatic int burst_cnt_width(input int max_burst);
    int w;
    w = $clog2(max_burst + 1);
    return (w < 3) ? 3 : w;
  endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Bundle of the two instruction ports, the data port and the RAM port seen by
// ram_arbiter. slave = arbiter side, master = requestors plus RAM model.
interface ram_arbiter_if;
  import cpu_types_pkg::*;

  logic [1:0]      iREN;
  word_t [1:0]     iaddr;
  logic [1:0]      iwait;
  word_t [1:0]     iload;

  logic            dREN;
  logic            dWEN;
  word_t           daddr;
  word_t           dstore;
  logic            dwait;
  word_t           dload;

  logic            ramREN;
  logic            ramWEN;
  word_t           ramaddr;
  word_t           ramstore;
  word_t           ramload;
  ramstate_t       ramstate;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

endinterface

// File: rtl/rr_picker.sv
// Two-way round-robin select: a lone request wins outright, a tie goes to the
// CPU named by ptr.
module rr_picker (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic       valid,
  output logic       idx
);

  // NOTE: every variable gets a default before the case so no path infers a latch.
  always_comb begin
    valid = |req;
    idx   = 1'b0;
    case (req)
      2'b01:   idx = 1'b0;
      2'b10:   idx = 1'b1;
      2'b11:   idx = ptr;
      default: idx = 1'b0;
    endcase
  end

endmodule

// File: rtl/ram_arbiter.sv
// Single-port RAM arbiter for two instruction fetch ports and one data port:
// data has priority, bounded by MAX_DBURST while instruction fetches wait.
module ram_arbiter
  import cpu_types_pkg::*;
#(
  parameter int MAX_DBURST = DEFAULT_MAX_DBURST
) (
  input  logic          CLK,
  input  logic          nRST,
  ram_arbiter_if.slave  bus
);

  localparam int              CW        = burst_cnt_width(MAX_DBURST);
  localparam logic [CW-1:0]   BURST_MAX = CW'(MAX_DBURST);

  arb_state_t     state;
  arb_state_t     state_next;
  arb_state_t     arb_choice;
  arb_state_t     out_state;
  logic           rr_ptr;
  logic           rr_next;
  logic [CW-1:0]  burst_cnt;
  logic [CW-1:0]  burst_next;

  logic           d_req;
  logic           i_pending;
  logic           owner_req;
  logic           done;
  logic           d_done;
  logic           i_done;
  logic           pick_valid;
  logic           pick_idx;

  logic [1:0]     iwait_c;
  word_t [1:0]    iload_c;
  logic           dwait_c;
  word_t          dload_c;
  logic           ram_ren_c;
  logic           ram_wen_c;
  word_t          ram_addr_c;
  word_t          ram_store_c;

  assign d_req     = bus.dREN | bus.dWEN;
  assign i_pending = |bus.iREN;

  always_comb begin
    owner_req = 1'b0;
    case (state)
      GNT_D:   owner_req = d_req;
      GNT_I0:  owner_req = bus.iREN[0];
      GNT_I1:  owner_req = bus.iREN[1];
      default: owner_req = 1'b0;
    endcase
  end

  assign done   = owner_req && (bus.ramstate == ACCESS);
  assign d_done = done && (state == GNT_D);
  assign i_done = done && ((state == GNT_I0) || (state == GNT_I1));

  // Arbitration on a completion cycle must see the post-completion pointer and
  // burst count, otherwise the same CPU or one extra data beat would win again.
  assign rr_next = i_done ? (state == GNT_I0) : rr_ptr;

  always_comb begin
    burst_next = burst_cnt;
    if (i_done || !i_pending)
      burst_next = '0;
    else if (d_done && (burst_cnt != BURST_MAX))
      burst_next = burst_cnt + 1'b1;
  end

  rr_picker u_rr_picker (
    .req   (bus.iREN),
    .ptr   (rr_next),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_comb begin
    arb_choice = IDLE;
    if (d_req && !((burst_next == BURST_MAX) && i_pending))
      arb_choice = GNT_D;
    else if (pick_valid)
      arb_choice = pick_idx ? GNT_I1 : GNT_I0;
  end

  // A grant is only released by completion or by its owner dropping the request.
  always_comb begin
    state_next = state;
    if (state == IDLE)
      state_next = arb_choice;
    else if (!owner_req)
      state_next = IDLE;
    else if (done)
      state_next = arb_choice;
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state     <= IDLE;
      rr_ptr    <= 1'b0;
      burst_cnt <= '0;
    end else begin
      state     <= state_next;
      rr_ptr    <= rr_next;
      burst_cnt <= burst_next;
    end
  end

  // Outputs decode as idle while reset is asserted, so an abandoned grant never
  // shows a completion pulse on its reset cycle.
  assign out_state = nRST ? state : IDLE;

  always_comb begin
    iwait_c     = 2'b11;
    iload_c     = '0;
    dwait_c     = 1'b1;
    dload_c     = '0;
    ram_ren_c   = 1'b0;
    ram_wen_c   = 1'b0;
    ram_addr_c  = '0;
    ram_store_c = '0;
    case (out_state)
      GNT_D: begin
        ram_addr_c = bus.daddr;
        dload_c    = bus.ramload;
        dwait_c    = !done;
        if (d_req) begin
          if (bus.dWEN) begin
            ram_wen_c   = 1'b1;
            ram_store_c = bus.dstore;
          end else begin
            ram_ren_c = 1'b1;
          end
        end
      end
      GNT_I0: begin
        ram_addr_c = bus.iaddr[0];
        ram_ren_c  = bus.iREN[0];
        iload_c[0] = bus.ramload;
        iwait_c[0] = !done;
      end
      GNT_I1: begin
        ram_addr_c = bus.iaddr[1];
        ram_ren_c  = bus.iREN[1];
        iload_c[1] = bus.ramload;
        iwait_c[1] = !done;
      end
      default: ;
    endcase
  end

  assign bus.iwait    = iwait_c;
  assign bus.iload    = iload_c;
  assign bus.dwait    = dwait_c;
  assign bus.dload    = dload_c;
  assign bus.ramREN   = ram_ren_c;
  assign bus.ramWEN   = ram_wen_c;
  assign bus.ramaddr  = ram_addr_c;
  assign bus.ramstore = ram_store_c;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: inputs change 1 ns after each rising edge and
// outputs are checked 1 ns later, well before the next edge.
module tb_ram_arbiter;
  import cpu_types_pkg::*;

  logic CLK = 1'b0;
  logic nRST;
  int   checks   = 0;
  int   failures = 0;

  always #5 CLK = ~CLK;

  ram_arbiter_if bus ();

  ram_arbiter #(.MAX_DBURST(4)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " iwait"},    64'(bus.iwait),    64'h3);
    check({tag, " dwait"},    64'(bus.dwait),    64'h1);
    check({tag, " ramREN"},   64'(bus.ramREN),   64'h0);
    check({tag, " ramWEN"},   64'(bus.ramWEN),   64'h0);
    check({tag, " ramaddr"},  64'(bus.ramaddr),  64'h0);
    check({tag, " ramstore"}, 64'(bus.ramstore), 64'h0);
    check({tag, " iload"},    64'(bus.iload),    64'h0);
    check({tag, " dload"},    64'(bus.dload),    64'h0);
  endtask

  initial begin
    word_t val;

    nRST         = 1'b0;
    bus.iREN     = 2'b00;
    bus.iaddr[0] = 32'h0000_0100;
    bus.iaddr[1] = 32'h0000_0200;
    bus.dREN     = 1'b0;
    bus.dWEN     = 1'b0;
    bus.daddr    = 32'h0;
    bus.dstore   = 32'h0;
    bus.ramload  = 32'h1234_5678;
    bus.ramstate = FREE;
    next_cycle();
    next_cycle();
    settle();
    check_reset_outputs("reset");

    // Both CPUs fetching: completions must alternate CPU0, CPU1, CPU0, CPU1.
    nRST     = 1'b1;
    bus.iREN = 2'b11;
    settle();
    check("rr idle ramREN", 64'(bus.ramREN), 64'h0);
    check("rr idle iwait",  64'(bus.iwait),  64'h3);
    for (int k = 0; k < 2; k++) begin
      next_cycle();
      bus.ramstate = FREE;
      settle();
      check("rr cpu0 ramaddr", 64'(bus.ramaddr), 64'h100);
      check("rr cpu0 ramREN",  64'(bus.ramREN),  64'h1);
      check("rr cpu0 wait",    64'(bus.iwait),   64'h3);
      next_cycle();
      val          = 32'hA000_0000 + 32'(k);
      bus.ramstate = ACCESS;
      bus.ramload  = val;
      settle();
      check("rr cpu0 done iwait", 64'(bus.iwait), 64'h2);
      check("rr cpu0 iload",      64'(bus.iload), {32'h0, val});
      next_cycle();
      bus.ramstate = FREE;
      settle();
      check("rr cpu1 ramaddr", 64'(bus.ramaddr), 64'h200);
      check("rr cpu1 wait",    64'(bus.iwait),   64'h3);
      next_cycle();
      val          = 32'hA100_0000 + 32'(k);
      bus.ramstate = ACCESS;
      bus.ramload  = val;
      settle();
      check("rr cpu1 done iwait", 64'(bus.iwait), 64'h1);
      check("rr cpu1 iload",      64'(bus.iload), {val, 32'h0});
    end

    // CPU0 granted again; RAM busy, then CPU0 withdraws its fetch.
    next_cycle();
    bus.ramstate = BUSY;
    bus.iREN     = 2'b01;
    settle();
    check("busy hold ramaddr", 64'(bus.ramaddr), 64'h100);
    check("busy hold ramREN",  64'(bus.ramREN),  64'h1);
    check("busy hold iwait",   64'(bus.iwait),   64'h3);
    next_cycle();
    bus.iREN = 2'b00;
    settle();
    check("drop ramREN", 64'(bus.ramREN), 64'h0);
    check("drop iwait",  64'(bus.iwait),  64'h3);
    next_cycle();
    bus.ramstate = FREE;
    settle();
    check("drop idle ramaddr", 64'(bus.ramaddr), 64'h0);
    check("drop idle ramREN",  64'(bus.ramREN),  64'h0);
    check("idle iload",        64'(bus.iload),   64'h0);

    // Data write (dREN and dWEN both high) beats a pending CPU0 fetch.
    next_cycle();
    bus.dREN   = 1'b1;
    bus.dWEN   = 1'b1;
    bus.daddr  = 32'h0000_0040;
    bus.dstore = 32'hDEAD_BEEF;
    bus.iREN   = 2'b01;
    settle();
    check("wr idle ramWEN", 64'(bus.ramWEN), 64'h0);
    check("wr idle dwait",  64'(bus.dwait),  64'h1);
    next_cycle();
    settle();
    check("wr ramWEN",   64'(bus.ramWEN),   64'h1);
    check("wr ramREN",   64'(bus.ramREN),   64'h0);
    check("wr ramaddr",  64'(bus.ramaddr),  64'h40);
    check("wr ramstore", 64'(bus.ramstore), 64'hDEAD_BEEF);
    check("wr dwait",    64'(bus.dwait),    64'h1);
    check("wr iwait",    64'(bus.iwait),    64'h3);
    next_cycle();
    bus.ramstate = ACCESS;
    settle();
    check("wr done dwait", 64'(bus.dwait), 64'h0);
    next_cycle();
    bus.ramstate = FREE;
    bus.dREN     = 1'b0;
    bus.dWEN     = 1'b0;
    settle();
    check("wr drop ramWEN", 64'(bus.ramWEN), 64'h0);
    check("wr drop dwait",  64'(bus.dwait),  64'h1);
    next_cycle();
    settle();
    check("after wr idle ramaddr", 64'(bus.ramaddr), 64'h0);
    next_cycle();
    settle();
    check("after wr cpu0 ramaddr", 64'(bus.ramaddr), 64'h100);
    check("after wr cpu0 ramREN",  64'(bus.ramREN),  64'h1);
    next_cycle();
    bus.ramstate = ACCESS;
    bus.ramload  = 32'hB000_0000;
    settle();
    check("after wr cpu0 iwait", 64'(bus.iwait), 64'h2);
    check("after wr cpu0 iload", 64'(bus.iload), {32'h0, 32'hB000_0000});
    next_cycle();
    bus.ramstate = FREE;
    bus.iREN     = 2'b00;
    settle();
    check("cpu0 drop ramREN", 64'(bus.ramREN), 64'h0);

    // Continuous data reads against a waiting CPU1: 4 data beats, 1 fetch, data again.
    next_cycle();
    bus.dREN  = 1'b1;
    bus.daddr = 32'h0000_0080;
    bus.iREN  = 2'b10;
    settle();
    check("burst idle ramREN", 64'(bus.ramREN), 64'h0);
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      bus.ramstate = FREE;
      settle();
      check("burst data ramaddr", 64'(bus.ramaddr), 64'h80);
      check("burst data ramREN",  64'(bus.ramREN),  64'h1);
      check("burst data dwait",   64'(bus.dwait),   64'h1);
      next_cycle();
      val          = 32'hD000_0000 + 32'(k);
      bus.ramstate = ACCESS;
      bus.ramload  = val;
      settle();
      check("burst data done dwait", 64'(bus.dwait), 64'h0);
      check("burst data dload",      64'(bus.dload), {32'h0, val});
    end
    next_cycle();
    bus.ramstate = FREE;
    settle();
    check("burst cpu1 ramaddr", 64'(bus.ramaddr), 64'h200);
    check("burst cpu1 dwait",   64'(bus.dwait),   64'h1);
    next_cycle();
    bus.ramstate = ACCESS;
    bus.ramload  = 32'hC100_0000;
    settle();
    check("burst cpu1 iwait", 64'(bus.iwait), 64'h1);
    check("burst cpu1 iload", 64'(bus.iload), {32'hC100_0000, 32'h0});
    check("burst cpu1 dwait", 64'(bus.dwait), 64'h1);
    next_cycle();
    bus.ramstate = FREE;
    settle();
    check("burst resume ramaddr", 64'(bus.ramaddr), 64'h80);
    check("burst resume ramREN",  64'(bus.ramREN),  64'h1);
    next_cycle();
    bus.dREN = 1'b0;
    bus.iREN = 2'b00;
    settle();
    check("data drop ramREN", 64'(bus.ramREN), 64'h0);
    check("data drop dwait",  64'(bus.dwait),  64'h1);

    // CPU0 completes, then CPU1 sits through 5 ERROR cycles.
    next_cycle();
    bus.iREN = 2'b11;
    settle();
    check("err idle ramREN", 64'(bus.ramREN), 64'h0);
    next_cycle();
    settle();
    check("err cpu0 ramaddr", 64'(bus.ramaddr), 64'h100);
    next_cycle();
    bus.ramstate = ACCESS;
    bus.ramload  = 32'hE000_0000;
    settle();
    check("err cpu0 iwait", 64'(bus.iwait), 64'h2);
    for (int k = 0; k < 5; k++) begin
      next_cycle();
      bus.ramstate = ERROR;
      settle();
      check("err hold ramaddr", 64'(bus.ramaddr), 64'h200);
      check("err hold ramREN",  64'(bus.ramREN),  64'h1);
      check("err hold iwait",   64'(bus.iwait),   64'h3);
    end
    next_cycle();
    bus.ramstate = ACCESS;
    bus.ramload  = 32'hE100_0000;
    settle();
    check("err cpu1 done iwait", 64'(bus.iwait), 64'h1);
    check("err cpu1 iload",      64'(bus.iload), {32'hE100_0000, 32'h0});

    // CPU0 completes (pointer now CPU1), data takes over, then reset mid-grant.
    next_cycle();
    bus.ramstate = FREE;
    bus.dREN     = 1'b1;
    settle();
    check("pre rst cpu0 ramaddr", 64'(bus.ramaddr), 64'h100);
    next_cycle();
    bus.ramstate = ACCESS;
    bus.ramload  = 32'hF000_0000;
    settle();
    check("pre rst cpu0 iwait", 64'(bus.iwait), 64'h2);
    next_cycle();
    bus.ramstate = FREE;
    settle();
    check("pre rst data ramaddr", 64'(bus.ramaddr), 64'h80);
    check("pre rst data ramREN",  64'(bus.ramREN),  64'h1);
    next_cycle();
    bus.ramstate = ACCESS;
    nRST         = 1'b0;
    settle();
    check("rst cycle dwait",   64'(bus.dwait),   64'h1);
    check("rst cycle ramREN",  64'(bus.ramREN),  64'h0);
    check("rst cycle ramaddr", 64'(bus.ramaddr), 64'h0);
    check("rst cycle dload",   64'(bus.dload),   64'h0);
    next_cycle();
    nRST         = 1'b1;
    bus.dREN     = 1'b0;
    bus.ramstate = FREE;
    settle();
    check_reset_outputs("after rst");
    next_cycle();
    settle();
    check("after rst rr ramaddr", 64'(bus.ramaddr), 64'h100);
    check("after rst rr ramREN",  64'(bus.ramREN),  64'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
